// File: rtl/lexington_pkg.sv
// Shared SoC constants: interrupt controller register map, id width and bus base address.
// Also carries the byte-lane write merge used by the bus-visible config registers.
package lexington;

  localparam int IRQ_MAX      = 32;
  localparam int IRQ_ID_WIDTH = 6;
  localparam int IRQ_ADDR_W   = 3;

  // Word slot on the data bus next to mtime.
  localparam logic [31:0] DEFAULT_IRQ_BASE_ADDR = 32'hFFFF_FF60;

  typedef enum logic [IRQ_ADDR_W-1:0] {
    IRQ_PENDING  = 3'd0,
    IRQ_ENABLE   = 3'd1,
    IRQ_MODE     = 3'd2,
    IRQ_CLAIM    = 3'd3,
    IRQ_COMPLETE = 3'd4,
    IRQ_STATUS   = 3'd5
  } irq_reg_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? wdat[8*b +: 8] : cur[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/irq_ctrl_sync.sv
// One interrupt source: SYNC_STAGES-deep synchroniser plus rising-edge detector.
// level lags irq_async by SYNC_STAGES edges; rise is a one-cycle pulse aligned with level.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_async,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_async};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: per-source edge/level capture, masking, lowest-index-first claim/complete.
// Reads are combinational from addr; all register and claim/complete side effects commit on the access edge.
module irq_ctrl
  import lexington::*;
#(
  parameter  int NUM_IRQ     = 10,
  parameter  int SYNC_STAGES = 2,
  localparam int ADDR_WIDTH  = IRQ_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_strobe,
  output logic [31:0]           rd_data,
  input  logic [NUM_IRQ-1:0]    irq_i,
  output logic                  irq_o
);

  logic [NUM_IRQ-1:0] lvl, rise;
  logic [NUM_IRQ-1:0] pending, enable, mode;
  logic [NUM_IRQ-1:0] cand, win_oh, w1c, claim_clr, en_next, mode_next;
  logic [IRQ_ID_WIDTH-1:0] win_id, claimed_id;
  logic                    busy;
  logic [IRQ_MAX-1:0]      pend_w, en_w, mode_w;
  logic [31:0]             en_merged, mode_merged;
  logic                    claim_fire, complete_hit;
  logic                    unused_bits;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst       (rst),
      .irq_async (irq_i[g]),
      .level     (lvl[g]),
      .rise      (rise[g])
    );
  end

  always_comb begin
    pend_w = '0;
    en_w   = '0;
    mode_w = '0;
    pend_w[NUM_IRQ-1:0] = pending;
    en_w[NUM_IRQ-1:0]   = enable;
    mode_w[NUM_IRQ-1:0] = mode;
  end

  assign en_merged   = strb_merge(en_w, wr_data, wr_strobe);
  assign mode_merged = strb_merge(mode_w, wr_data, wr_strobe);
  assign en_next     = (wr_en && addr == IRQ_ENABLE) ? en_merged[NUM_IRQ-1:0] : enable;
  assign mode_next   = (wr_en && addr == IRQ_MODE) ? mode_merged[NUM_IRQ-1:0] : mode;
  assign w1c         = (wr_en && addr == IRQ_PENDING) ? wr_data[NUM_IRQ-1:0] : '0;
  assign unused_bits = ^{en_merged, mode_merged, wr_data};

  // Scan from the top so the lowest active index is the last one to land.
  assign cand = pending & enable;
  always_comb begin
    win_id = '0;
    win_oh = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_id    = IRQ_ID_WIDTH'(i + 1);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  assign irq_o        = !busy && (|cand);
  assign claim_fire   = rd_en && (addr == IRQ_CLAIM) && irq_o;
  assign claim_clr    = claim_fire ? (win_oh & mode) : '0;
  assign complete_hit = wr_en && (addr == IRQ_COMPLETE) && wr_strobe[0] && busy &&
                        (wr_data[IRQ_ID_WIDTH-1:0] == claimed_id);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      enable     <= '0;
      mode       <= '0;
      busy       <= 1'b0;
      claimed_id <= '0;
    end else begin
      enable <= en_next;
      mode   <= mode_next;
      // Level bits track the synchronised line; leaving level for edge wipes the bit.
      // Edge bits: a fresh rise beats a same-cycle claim clear or W1C.
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (!mode[i]) pending[i] <= mode_next[i] ? 1'b0 : lvl[i];
        else          pending[i] <= (pending[i] & ~(w1c[i] | claim_clr[i])) | rise[i];
      end
      if (claim_fire) begin
        busy       <= 1'b1;
        claimed_id <= win_id;
      end else if (complete_hit) begin
        busy       <= 1'b0;
        claimed_id <= '0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      case (addr)
        IRQ_PENDING: rd_data = pend_w;
        IRQ_ENABLE:  rd_data = en_w;
        IRQ_MODE:    rd_data = mode_w;
        IRQ_CLAIM:   rd_data = irq_o ? 32'(win_id) : '0;
        IRQ_STATUS:  rd_data = {{(24 - IRQ_ID_WIDTH){1'b0}}, claimed_id, 7'b0, busy};
        default:     rd_data = '0;
      endcase
    end
  end

endmodule
